// File: rtl/mc_control_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: states, opcodes, mux selects, trap causes,
// plus the small opcode-decode helpers used by the controller.
package mc_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_ITYPE, OP_RTYPE: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // Branch and JAL targets are formed by the ALU as oldPC + imm.
  function automatic logic alu_a_oldpc(input logic [6:0] op);
    return (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_BRANCH);
  endfunction

  function automatic logic alu_b_imm(input logic [6:0] op);
    return op != OP_RTYPE;
  endfunction

  function automatic logic [1:0] wb_sel_for(input logic [6:0] op);
    case (op)
      OP_LOAD:         return WB_MEM;
      OP_JAL, OP_JALR: return WB_PC4;
      OP_LUI:          return WB_IMM;
      default:         return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the sequencer (master) and the datapath/memory port (slave).
interface mc_control_if;
  logic [6:0] ir_opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       oldpc_we;
  logic       alu_a_sel;
  logic       alu_b_sel;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       retire;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  ir_opcode, branch_taken, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, pc_sel, oldpc_we, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, retire, trap, trap_cause
  );

  modport slave (
    output ir_opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, pc_sel, oldpc_we, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, retire, trap, trap_cause
  );
endinterface

// File: rtl/mc_mem_wait.sv
// Memory wait counter: counts stalled request cycles, flags timeout on the WAIT_LIMIT-th stalled cycle.
// Timeout is combinational from the current count and req/ready; WAIT_LIMIT=0 disables it.
module mc_mem_wait #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam int W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  logic [W-1:0] cnt;

  // Every request phase starts from a non-requesting cycle or a completed one, so this clears on entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!req || ready) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + W'(1);
    end
  end

  generate
    if (WAIT_LIMIT == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      assign timeout = req & ~ready & (cnt == W'(WAIT_LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/mc_control.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB, traps on illegal opcode or memory timeout.
// Optional MC_PERF_CNT_EN adds cyc_cnt/ret_cnt. Memory stalls extend FETCH/MEM one cycle each.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
`ifdef MC_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_control_if.master      bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  ret_cnt
`endif
);

  state_t     state;
  logic [6:0] op_q;
  logic       trap_q;
  logic [1:0] cause_q;
  logic       timeout;

  logic       mem_req, mem_we, ir_we, pc_we, oldpc_we;
  logic       alu_a_sel, alu_b_sel, rf_we, retire;
  logic [1:0] pc_sel, wb_sel;

  mc_mem_wait #(.WAIT_LIMIT(WAIT_LIMIT)) u_mem_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (mem_req),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  // Everything is gated by rst_n so an outstanding request drops in the reset cycle itself.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    oldpc_we  = 1'b0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_we    = 1'b1;
            oldpc_we = 1'b1;
            pc_we    = 1'b1;
          end
        end
        ST_EXEC: begin
          alu_a_sel = alu_a_oldpc(op_q);
          alu_b_sel = alu_b_imm(op_q);
          if (op_q == OP_BRANCH) begin
            pc_we  = bus.branch_taken;
            pc_sel = PC_TARGET;
            retire = 1'b1;
          end
        end
        ST_MEM: begin
          alu_a_sel = alu_a_oldpc(op_q);
          alu_b_sel = alu_b_imm(op_q);
          mem_req   = 1'b1;
          mem_we    = (op_q == OP_STORE);
          retire    = bus.mem_ready && (op_q == OP_STORE);
        end
        ST_WB: begin
          alu_a_sel = alu_a_oldpc(op_q);
          alu_b_sel = alu_b_imm(op_q);
          rf_we     = 1'b1;
          retire    = 1'b1;
          wb_sel    = wb_sel_for(op_q);
          if (op_q == OP_JAL) begin
            pc_we  = 1'b1;
            pc_sel = PC_TARGET;
          end else if (op_q == OP_JALR) begin
            pc_we  = 1'b1;
            pc_sel = PC_JALR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      op_q    <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            state <= ST_DECODE;
          end else if (timeout) begin
            state   <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: begin
          op_q <= bus.ir_opcode;
          if (is_legal(bus.ir_opcode)) begin
            state <= ST_EXEC;
          end else begin
            state   <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_LOAD || op_q == OP_STORE) state <= ST_MEM;
          else if (op_q == OP_BRANCH)              state <= ST_FETCH;
          else                                     state <= ST_WB;
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            state <= (op_q == OP_STORE) ? ST_FETCH : ST_WB;
          end else if (timeout) begin
            state   <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state != ST_TRAP) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (retire)           ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end
`endif

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.oldpc_we   = oldpc_we;
  assign bus.alu_a_sel  = alu_a_sel;
  assign bus.alu_b_sel  = alu_b_sel;
  assign bus.rf_we      = rf_we;
  assign bus.wb_sel     = wb_sel;
  assign bus.retire     = retire;
  assign bus.trap       = trap_q & rst_n;
  assign bus.trap_cause = rst_n ? cause_q : CAUSE_NONE;

endmodule
